ad9361_tx_sample_reader: RTL and testbench
==========================================

Name: ad9361_tx_sample_reader

Overview:
- Reader end of the DAC-path async FIFO, running in the AD9361_CLK domain.
- Pops {Q,I} samples over AXI-Stream into a small local elastic buffer, prefills, then emits one sample per RATE_DIV clocks to the AD9361 TX data inputs.
- Underrun is detected explicitly (zero insertion, then re-prefill) instead of reading blindly with tready tied high.

Parameters:
- DATA_W, 12, I and Q sample width; tdata is 2*DATA_W.
- DEPTH, 8, local buffer depth in samples; power of 2, >=4.
- PREFILL, 4, fill level required to leave PREFILL; 1..DEPTH.
- RATE_DIV, 1, AD9361_CLK cycles per output sample; >=1.

Ports:
- AD9361_CLK  in  1  block clock.
- rst_32d768M  in  1  reset.
- enable  in  1  run request, synchronous to AD9361_CLK.
- s_axis_tvalid  in  1  FIFO master valid.
- s_axis_tready  out  1  ready to FIFO master.
- s_axis_tdata  in  2*DATA_W  [DATA_W-1:0]=I, [2*DATA_W-1:DATA_W]=Q.
- tx_i  out  DATA_W  registered I to TX interface.
- tx_q  out  DATA_W  registered Q to TX interface.
- tx_strobe  out  1  one-cycle pulse, new tx_i/tx_q valid.
- underrun  out  1  one-cycle pulse on an empty-at-tick event.
- state_o  out  2  current state encoding.
- fill_level  out  clog2(DEPTH)+1  local buffer occupancy.

Behaviour:
- Reset: rst_32d768M is asynchronous, active-high; the clock is AD9361_CLK.
- Outputs in reset: tx_i=0, tx_q=0, tx_strobe=0, underrun=0, s_axis_tready=0, fill_level=0, state=IDLE, divider=0.
- States: IDLE=0, PREFILL=1, RUN=2.
- IDLE:
  - tready=0, buffer flushed, outputs held at 0.
  - enable=1 moves to PREFILL on the next edge.
- PREFILL:
  - tready = !full.
  - A push occurs when tvalid && tready.
  - When fill_level (after this cycle's push) >= PREFILL, the next state is RUN and the divider is reset to 0.
- RUN:
  - tready = !full.
  - A tick occurs when the divider == 0; the divider counts 0..RATE_DIV-1 and wraps.
  - Tick with fill>0: pop the head; tx_i/tx_q are registered from it on the same edge; tx_strobe=1 for one cycle.
  - Tick with fill==0: tx_i=tx_q=0, tx_strobe=1, underrun=1 for one cycle; next state PREFILL.
- enable=0 in any state: next state IDLE, buffer flushed at that edge, tx_i/tx_q=0, no strobe.
- Ready and occupancy:
  - s_axis_tready is decoded combinationally from registered state and count only; it never depends on tvalid.
  - Push and pop in the same cycle leave fill unchanged.
  - Full blocks the push even if a pop occurs that cycle.
  - fill_level never exceeds DEPTH and never underflows.
- Latency:
  - The first strobe is on the first edge after entering RUN, i.e. PREFILL-complete edge + 1.
  - A sample pushed into a non-empty buffer appears after the samples already queued.
  - Data order is strictly FIFO.
- Pointers are clog2(DEPTH) bits and wrap naturally; the occupancy counter is one bit wider.
- Reset asserted mid-run: all state is cleared immediately, asynchronously. After release the block is in IDLE, regardless of enable, until the first clock edge.

Optional Feature:
- Macro: TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [15:0], which increments on each underrun pulse, saturates at 0xFFFF, and clears only on reset.
- Undefined: the port and counter are absent; only the underrun pulse exists.

Decomposition:
- Shared package holds:
  - the state typedef (IDLE/PREFILL/RUN);
  - the sample-field slicing constants (I_LSB=0, Q_LSB=DATA_W);
  - the underrun counter width.
- One sub-module: tx_elastic_buf. It is a synchronous DEPTH-entry FIFO with push, pop, flush, full, empty and count, using the same clock and reset.
- The reader FSM, divider and output registers stay in the top-level module.

Test Plan:
1. Reset/IDLE: assert rst_32d768M mid-RUN with fill=5 -> tx_i/tx_q/tx_strobe/tready go to 0 immediately; fill_level=0; state_o=0.
2. Prefill and order (DEPTH=8, PREFILL=4, RATE_DIV=1):
   - Stimulus: enable=1, push I=0x001..0x006 with Q=0x801..0x806 back-to-back.
   - Response: RUN entered after the 4th push; tx_strobe every cycle; outputs 0x001/0x801 ... 0x006/0x806 in order.
3. Underrun: stop tvalid after 6 samples -> the 7th tick gives zeros, tx_strobe=1, underrun=1 for one cycle, state PREFILL. Output resumes after 4 new pushes. With TX_UNDERRUN_CNT_EN, underrun_cnt=1.
4. Full back-pressure (enable=1, tvalid held high, RATE_DIV=8):
   - fill reaches 8 -> tready=0.
   - After each tick pop, tready=1 for one cycle and fill returns to 8.
   - No sample is lost or duplicated.
5. Pacing: RATE_DIV=4, steady supply -> tx_strobe exactly every 4th cycle; fill_level stable.
6. enable drop mid-RUN with fill=3 -> next edge IDLE, fill_level=0, no further strobes. Re-enable restarts PREFILL from empty.

Source files
------------

// File: rtl/ad9361_tx_sample_reader_pkg.sv
// ----------------------------------------------------------------------------
// ad9361_tx_sample_reader_pkg
// Shared definitions for the AD9361 TX sample reader:
//   - state_t and the IDLE/PREFILL/RUN encodings
//   - {Q,I} field positions inside a tdata word
//   - width of the optional underrun event counter
// ----------------------------------------------------------------------------
package ad9361_tx_sample_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PREFILL = 2'd1;
    localparam state_t ST_RUN     = 2'd2;

    // I occupies the low half of tdata, Q the high half.
    localparam int I_LSB = 0;

    function automatic int q_lsb(input int data_w);
        return data_w;
    endfunction

    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/ad9361_tx_sample_reader_if.sv
// ----------------------------------------------------------------------------
// ad9361_tx_sample_reader_if
// AXI-Stream sample channel from the DAC-path async FIFO to the TX reader.
//   tvalid  master -> slave   sample available
//   tready  slave  -> master  sample accepted when tvalid && tready
//   tdata   master -> slave   {Q, I}, each DATA_W bits
// ----------------------------------------------------------------------------
interface ad9361_tx_sample_reader_if #(
    parameter int DATA_W = 12
);
    logic                  tvalid;
    logic                  tready;
    logic [2*DATA_W-1:0]   tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/ad9361_tx_sample_reader_tx_elastic_buf.sv
// ----------------------------------------------------------------------------
// tx_elastic_buf
// Synchronous DEPTH-entry FIFO used as the local elastic buffer of the reader.
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write one entry (ignored when full or flushing)
//   pop, rdata    rdata is the head entry; pop removes it (ignored when empty)
//   flush         empties the buffer at the next edge, overrides push/pop
//   full, empty   occupancy flags
//   count         occupancy, one bit wider than the pointers
// ----------------------------------------------------------------------------
module tx_elastic_buf #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are a power of two deep and simply wrap.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ad9361_tx_sample_reader.sv
// ----------------------------------------------------------------------------
// ad9361_tx_sample_reader
// Reader end of the DAC-path async FIFO in the AD9361_CLK domain. Pops {Q,I}
// samples into a local elastic buffer, prefills it, then emits one sample per
// RATE_DIV clocks. An empty buffer at an output tick emits zeros, flags an
// underrun and returns to prefill.
//   AD9361_CLK, rst_32d768M  clock, asynchronous active-high reset
//   enable                   run request (low: idle and flush)
//   s_axis                   AXI-Stream slave, tdata = {Q, I}
//   tx_i, tx_q, tx_strobe    registered sample and one-cycle new-sample pulse
//   underrun                 one-cycle pulse when a tick finds the buffer empty
//   state_o, fill_level      current state (IDLE=0, PREFILL=1, RUN=2), occupancy
// Optional: define TX_UNDERRUN_CNT_EN to add underrun_cnt[15:0], a saturating
// count of underrun pulses cleared only by reset.
// ----------------------------------------------------------------------------
module ad9361_tx_sample_reader
    import ad9361_tx_sample_reader_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 8,
    parameter int PREFILL  = 4,
    parameter int RATE_DIV = 1
) (
    input  logic                      AD9361_CLK,
    input  logic                      rst_32d768M,
    input  logic                      enable,
    ad9361_tx_sample_reader_if.slave  s_axis,
    output logic [DATA_W-1:0]         tx_i,
    output logic [DATA_W-1:0]         tx_q,
    output logic                      tx_strobe,
    output logic                      underrun,
    output logic [1:0]                state_o,
    output logic [$clog2(DEPTH):0]    fill_level
`ifdef TX_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int Q_LSB = q_lsb(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(RATE_DIV - 1);
    localparam logic [CNT_W-1:0] PREFILL_LVL = CNT_W'(PREFILL);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]   tx_i_q, tx_i_d, tx_q_q, tx_q_d;
    logic                tx_strobe_q, tx_strobe_d;
    logic                underrun_q, underrun_d;

    logic                ready, push, pop, flush;
    logic                buf_full, buf_empty;
    logic [CNT_W-1:0]    buf_count, fill_after_push;
    logic [2*DATA_W-1:0] head;

    // Ready depends only on registered state and occupancy, never on tvalid.
    assign ready           = (state_q != ST_IDLE) && !buf_full;
    assign s_axis.tready   = ready;
    assign push            = s_axis.tvalid && ready;
    assign fill_after_push = buf_count + CNT_W'(push);

    tx_elastic_buf #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (AD9361_CLK),
        .rst   (rst_32d768M),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (s_axis.tdata),
        .rdata (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tx_i_d      = tx_i_q;
        tx_q_d      = tx_q_q;
        tx_strobe_d = 1'b0;
        underrun_d  = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            div_d   = '0;
            tx_i_d  = '0;
            tx_q_d  = '0;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    flush   = 1'b1;
                    div_d   = '0;
                    tx_i_d  = '0;
                    tx_q_d  = '0;
                    state_d = ST_PREFILL;
                end
                ST_PREFILL: begin
                    // Divider restarts so the first tick lands on the first RUN cycle.
                    div_d = '0;
                    if (fill_after_push >= PREFILL_LVL) state_d = ST_RUN;
                end
                ST_RUN: begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                    if (div_q == '0) begin
                        tx_strobe_d = 1'b1;
                        if (!buf_empty) begin
                            pop    = 1'b1;
                            tx_i_d = head[I_LSB +: DATA_W];
                            tx_q_d = head[Q_LSB +: DATA_W];
                        end else begin
                            underrun_d = 1'b1;
                            tx_i_d     = '0;
                            tx_q_d     = '0;
                            div_d      = '0;
                            state_d    = ST_PREFILL;
                        end
                    end
                end
                default: begin
                    flush   = 1'b1;
                    div_d   = '0;
                    tx_i_d  = '0;
                    tx_q_d  = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge AD9361_CLK or posedge rst_32d768M) begin
        if (rst_32d768M) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            tx_i_q      <= '0;
            tx_q_q      <= '0;
            tx_strobe_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tx_i_q      <= tx_i_d;
            tx_q_q      <= tx_q_d;
            tx_strobe_q <= tx_strobe_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_i       = tx_i_q;
    assign tx_q       = tx_q_q;
    assign tx_strobe  = tx_strobe_q;
    assign underrun   = underrun_q;
    assign state_o    = state_q;
    assign fill_level = buf_count;

`ifdef TX_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

    // Counts on the same edge that raises the underrun pulse; sticks at all-ones.
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_d && (underrun_cnt_q != '1))
            underrun_cnt_d = underrun_cnt_q + UNDERRUN_CNT_W'(1);
    end

    always_ff @(posedge AD9361_CLK or posedge rst_32d768M) begin
        if (rst_32d768M) underrun_cnt_q <= '0;
        else             underrun_cnt_q <= underrun_cnt_d;
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_ad9361_tx_sample_reader.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ad9361_tx_sample_reader
// Two instances share clock and reset: dut_a (RATE_DIV=1) runs the vector
// table and a randomized run against a queue-based reference model; dut_b
// (RATE_DIV=4) covers back-pressure, pacing, enable drop and async reset.
// ----------------------------------------------------------------------------
module tb_ad9361_tx_sample_reader;
    localparam int DATA_W  = 12;
    localparam int DEPTH   = 8;
    localparam int PREFILL = 4;
    localparam int RATE_A  = 1;
    localparam int RATE_B  = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    logic en_a, en_b;
    always #5 clk = ~clk;

    ad9361_tx_sample_reader_if #(.DATA_W(DATA_W)) a_if ();
    ad9361_tx_sample_reader_if #(.DATA_W(DATA_W)) b_if ();

    logic [DATA_W-1:0] tx_i_a, tx_q_a, tx_i_b, tx_q_b;
    logic              str_a, und_a, str_b, und_b;
    logic [1:0]        st_a, st_b;
    logic [CNT_W-1:0]  fill_a, fill_b;
`ifdef TX_UNDERRUN_CNT_EN
    logic [15:0]       ucnt_a, ucnt_b;
`endif

    ad9361_tx_sample_reader #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PREFILL(PREFILL), .RATE_DIV(RATE_A)
    ) u_dut_a (
        .AD9361_CLK(clk), .rst_32d768M(rst), .enable(en_a), .s_axis(a_if),
        .tx_i(tx_i_a), .tx_q(tx_q_a), .tx_strobe(str_a), .underrun(und_a),
        .state_o(st_a), .fill_level(fill_a)
`ifdef TX_UNDERRUN_CNT_EN
        , .underrun_cnt(ucnt_a)
`endif
    );

    ad9361_tx_sample_reader #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PREFILL(PREFILL), .RATE_DIV(RATE_B)
    ) u_dut_b (
        .AD9361_CLK(clk), .rst_32d768M(rst), .enable(en_b), .s_axis(b_if),
        .tx_i(tx_i_b), .tx_q(tx_q_b), .tx_strobe(str_b), .underrun(und_b),
        .state_o(st_b), .fill_level(fill_b)
`ifdef TX_UNDERRUN_CNT_EN
        , .underrun_cnt(ucnt_b)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample number n -> {Q, I}; I = n, Q = 0x800 | n (zero word for n = 0).
    function automatic logic [23:0] sample(input int n);
        logic [11:0] i;
        i = 12'(n);
        return (n == 0) ? 24'h0 : {12'h800 | i, i};
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        en;
        logic        tv;
        logic [11:0] n;
        logic        e_str;
        logic        e_und;
        logic [11:0] e_n;
        logic [1:0]  e_st;
        logic [3:0]  e_fill;
    } vec_t;

    function automatic vec_t mk(input int en, tv, n, es, eu, en_out, est, ef);
        vec_t v;
        v.en = 1'(en); v.tv = 1'(tv); v.n = 12'(n);
        v.e_str = 1'(es); v.e_und = 1'(eu); v.e_n = 12'(en_out);
        v.e_st = 2'(est); v.e_fill = 4'(ef);
        return v;
    endfunction

    // ---------------- reference model for dut_a ----------------
    typedef enum int {P_IDLE = 0, P_PRE = 1, P_RUN = 2} phase_e;
    phase_e      m_phase;
    logic [23:0] mq [$];
    int          m_div;
    logic [11:0] m_i, m_q;
    logic        m_str, m_und;
    int          exp_ucnt = 0;

    task automatic model_step(input bit en, input bit push, input logic [23:0] d);
        logic [23:0] s;
        m_str = 1'b0;
        m_und = 1'b0;
        if (!en) begin
            m_phase = P_IDLE; mq.delete(); m_i = '0; m_q = '0; m_div = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    mq.delete();
                    m_phase = P_PRE;
                end
                P_PRE: begin
                    if (push) mq.push_back(d);
                    if (mq.size() >= PREFILL) begin m_phase = P_RUN; m_div = 0; end
                end
                default: begin
                    if (m_div == 0) begin
                        m_str = 1'b1;
                        if (mq.size() > 0) begin
                            s   = mq.pop_front();
                            m_i = s[11:0];
                            m_q = s[23:12];
                        end else begin
                            m_i = '0; m_q = '0; m_und = 1'b1; m_phase = P_PRE;
                            if (exp_ucnt < 65535) exp_ucnt++;
                        end
                    end
                    m_div = (m_und) ? 0 : (m_div + 1) % RATE_A;
                    if (push) mq.push_back(d);
                end
            endcase
        end
    endtask

    // ---------------- dut_b streaming run ----------------
    // Source presents samples 1,2,3... holding each until accepted; tvalid held high.
    task automatic run_b(input int n_edges);
        int  seq, seq_out, f_exp;
        bit  acc, s_exp;
        seq = 1; seq_out = 1;
        b_if.tdata = sample(seq); b_if.tvalid = 1'b1; en_b = 1'b1;
        for (int k = 1; k <= n_edges; k++) begin
            acc = b_if.tready;
            @(posedge clk); @(negedge clk);
            if (acc) begin seq++; b_if.tdata = sample(seq); end
            // Edge 1 enters PREFILL, edges 2..5 push, edge 6 is the first tick.
            s_exp = (k >= 6) && (((k - 6) % RATE_B) == 0);
            f_exp = (k <= 5) ? k - 1 : (k <= 9) ? k - 2 : (s_exp ? DEPTH - 1 : DEPTH);
            check($sformatf("b_strobe_k%0d", k), str_b, s_exp);
            check($sformatf("b_fill_k%0d", k), fill_b, f_exp);
            check($sformatf("b_tready_k%0d", k), b_if.tready, f_exp < DEPTH);
            check($sformatf("b_state_k%0d", k), st_b, (k <= 4) ? 1 : 2);
            check($sformatf("b_underrun_k%0d", k), und_b, 0);
            if (s_exp) begin
                check($sformatf("b_tx_i_k%0d", k), tx_i_b, seq_out);
                check($sformatf("b_tx_q_k%0d", k), tx_q_b, 32'h800 | seq_out);
                seq_out++;
            end
        end
    endtask

    vec_t vecs [22];
    logic [23:0] es;
    int p;
    bit push_a, rdy_a;

    initial begin
        vecs[0]  = mk(1,0, 0, 0,0, 0, 1,0);
        vecs[1]  = mk(1,1, 1, 0,0, 0, 1,1);
        vecs[2]  = mk(1,1, 2, 0,0, 0, 1,2);
        vecs[3]  = mk(1,1, 3, 0,0, 0, 1,3);
        vecs[4]  = mk(1,1, 4, 0,0, 0, 2,4);
        vecs[5]  = mk(1,1, 5, 1,0, 1, 2,4);
        vecs[6]  = mk(1,1, 6, 1,0, 2, 2,4);
        vecs[7]  = mk(1,0, 0, 1,0, 3, 2,3);
        vecs[8]  = mk(1,0, 0, 1,0, 4, 2,2);
        vecs[9]  = mk(1,0, 0, 1,0, 5, 2,1);
        vecs[10] = mk(1,0, 0, 1,0, 6, 2,0);
        vecs[11] = mk(1,0, 0, 1,1, 0, 1,0);
        vecs[12] = mk(1,0, 0, 0,0, 0, 1,0);
        vecs[13] = mk(1,1, 7, 0,0, 0, 1,1);
        vecs[14] = mk(1,1, 8, 0,0, 0, 1,2);
        vecs[15] = mk(1,1, 9, 0,0, 0, 1,3);
        vecs[16] = mk(1,1,10, 0,0, 0, 2,4);
        vecs[17] = mk(1,0, 0, 1,0, 7, 2,3);
        vecs[18] = mk(0,0, 0, 0,0, 0, 0,0);
        vecs[19] = mk(0,0, 0, 0,0, 0, 0,0);
        vecs[20] = mk(1,0, 0, 0,0, 0, 1,0);
        vecs[21] = mk(0,0, 0, 0,0, 0, 0,0);

        // ---- reset state ----
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        a_if.tvalid = 1'b0; a_if.tdata = '0;
        b_if.tvalid = 1'b0; b_if.tdata = '0;
        repeat (3) @(negedge clk);
        check("rst_a_tx_i", tx_i_a, 0);
        check("rst_a_tx_q", tx_q_a, 0);
        check("rst_a_strobe", str_a, 0);
        check("rst_a_underrun", und_a, 0);
        check("rst_a_tready", a_if.tready, 0);
        check("rst_a_fill", fill_a, 0);
        check("rst_a_state", st_a, 0);
        check("rst_b_tready", b_if.tready, 0);
        check("rst_b_state", st_b, 0);

        // Released with enable high: IDLE until the first edge, PREFILL after it.
        en_a = 1'b1; en_b = 1'b1;
        #2 rst = 1'b0;
        #1 check("release_a_state_before_edge", st_a, 0);
        check("release_b_state_before_edge", st_b, 0);
        @(negedge clk);
        check("release_a_state_after_edge", st_a, 1);
        en_a = 1'b0; en_b = 1'b0;
        @(negedge clk);
        check("disable_a_state", st_a, 0);

        // ---- table: prefill, order, underrun, re-prefill, enable drop ----
        for (int k = 0; k < 22; k++) begin
            en_a = vecs[k].en;
            a_if.tvalid = vecs[k].tv;
            a_if.tdata = sample(int'(vecs[k].n));
            @(posedge clk); @(negedge clk);
            es = sample(int'(vecs[k].e_n));
            if (vecs[k].e_und) exp_ucnt++;
            check($sformatf("vec%0d_strobe", k), str_a, vecs[k].e_str);
            check($sformatf("vec%0d_underrun", k), und_a, vecs[k].e_und);
            check($sformatf("vec%0d_tx_i", k), tx_i_a, es[11:0]);
            check($sformatf("vec%0d_tx_q", k), tx_q_a, es[23:12]);
            check($sformatf("vec%0d_state", k), st_a, vecs[k].e_st);
            check($sformatf("vec%0d_fill", k), fill_a, vecs[k].e_fill);
`ifdef TX_UNDERRUN_CNT_EN
            check($sformatf("vec%0d_underrun_cnt", k), ucnt_a, exp_ucnt);
`endif
        end

        // ---- randomized run against the model ----
        m_phase = P_IDLE; m_div = 0; m_i = '0; m_q = '0; m_str = 1'b0; m_und = 1'b0;
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            case ((c / 50) % 4)
                0:       p = 95;
                1:       p = 60;
                2:       p = 25;
                default: p = 100;
            endcase
            en_a = ($urandom_range(0, 99) >= 2);
            a_if.tvalid = ($urandom_range(0, 99) < p);
            a_if.tdata = 24'($urandom);
            rdy_a = (m_phase != P_IDLE) && (mq.size() < DEPTH);
            check($sformatf("rnd%0d_tready", c), a_if.tready, rdy_a);
            push_a = a_if.tvalid && rdy_a;
            @(posedge clk);
            model_step(en_a, push_a, a_if.tdata);
            @(negedge clk);
            check($sformatf("rnd%0d_strobe", c), str_a, m_str);
            check($sformatf("rnd%0d_underrun", c), und_a, m_und);
            check($sformatf("rnd%0d_tx_i", c), tx_i_a, m_i);
            check($sformatf("rnd%0d_tx_q", c), tx_q_a, m_q);
            check($sformatf("rnd%0d_state", c), st_a, int'(m_phase));
            check($sformatf("rnd%0d_fill", c), fill_a, mq.size());
`ifdef TX_UNDERRUN_CNT_EN
            check($sformatf("rnd%0d_underrun_cnt", c), ucnt_a, exp_ucnt);
`endif
        end
        en_a = 1'b0; a_if.tvalid = 1'b0;

        // ---- dut_b: back-pressure at full, pacing every RATE_B cycles ----
        run_b(60);

        // Enable drop mid-run: IDLE and empty on the next edge, strobes stop.
        en_b = 1'b0;
        @(posedge clk); @(negedge clk);
        check("b_drop_state", st_b, 0);
        check("b_drop_fill", fill_b, 0);
        check("b_drop_tx_i", tx_i_b, 0);
        check("b_drop_tx_q", tx_q_b, 0);
        check("b_drop_tready", b_if.tready, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("b_idle_strobe_%0d", k), str_b, 0);
        end

        // ---- async reset mid-RUN with fill 5 ----
        run_b(7);
        #2 rst = 1'b1;
        #1;
        check("arst_b_tx_i", tx_i_b, 0);
        check("arst_b_tx_q", tx_q_b, 0);
        check("arst_b_strobe", str_b, 0);
        check("arst_b_tready", b_if.tready, 0);
        check("arst_b_fill", fill_b, 0);
        check("arst_b_state", st_b, 0);
        @(negedge clk);
        en_b = 1'b0; b_if.tvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_arst_b_state", st_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not end, got timeout expected completion");
        $fatal(1, "watchdog timeout");
    end

endmodule
